sa_cache: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate cache controller with integrated tag/data arrays and tree pseudo-LRU replacement. Successor to the direct-mapped cache FSM: same CPU-side and memory-side request/response protocol, generalised in ways, sets and line width. Sits between the core's load/store port and the line-granular memory controller.

---
 rtl/sa_cache_if.sv | 33 +++
 rtl/sa_cache.sv | 245 ++++++++++++++++++++++++
 tb/tb_sa_cache.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sa_cache_if.sv
// CPU-side and memory-side request/response bundle for sa_cache.
// slave = cache view, master = core / memory-controller view.
interface sa_cache_if #(
   parameter int ADDR_W     = 32,
   parameter int LINE_WORDS = 4
);
   logic                       cpu_req_valid;
   logic                       cpu_req_rw;
   logic [ADDR_W-1:0]          cpu_req_addr;
   logic [31:0]                cpu_req_data;
   logic                       cpu_res_ready;
   logic [31:0]                cpu_res_data;
   logic                       mem_req_valid;
   logic                       mem_req_rw;
   logic [ADDR_W-1:0]          mem_req_addr;
   logic [32*LINE_WORDS-1:0]   mem_req_data;
   logic                       mem_data_ready;
   logic [32*LINE_WORDS-1:0]   mem_data_data;

   modport slave (
      input  cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_data,
      output cpu_res_ready, cpu_res_data,
      output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
      input  mem_data_ready, mem_data_data
   );

   modport master (
      output cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_data,
      input  cpu_res_ready, cpu_res_data,
      input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
      output mem_data_ready, mem_data_data
   );
endinterface

// File: rtl/sa_cache.sv
// N-way set-associative write-back/write-allocate cache with tree pseudo-LRU.
// Optional macro SA_CACHE_STATS_EN adds saturating hit/miss/write-back counters.
//
// state        | meaning
// S_IDLE       | waiting for cpu_req_valid
// S_COMPARE    | tag lookup; hit completes, miss picks and latches a victim
// S_WRITE_BACK | dirty victim line being written to memory
// S_ALLOCATE   | line fill from memory into the victim way
module sa_cache #(
   parameter int WAYS       = 2,
   parameter int SETS       = 256,
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 32
) (
   input  logic        i_clk,
   input  logic        i_rst,
   sa_cache_if.slave   bus
`ifdef SA_CACHE_STATS_EN
   ,
   output logic [31:0] o_stat_hits,
   output logic [31:0] o_stat_misses,
   output logic [31:0] o_stat_writebacks
`endif
);
   localparam int OFFSET_W = $clog2(LINE_WORDS) + 2;
   localparam int INDEX_W  = $clog2(SETS);
   localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
   localparam int WORD_W   = OFFSET_W - 2;
   localparam int LINE_W   = 32 * LINE_WORDS;
   localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int PLRU_W   = (WAYS > 1) ? WAYS - 1 : 1;
   localparam int LEVELS   = $clog2(WAYS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPARE,
      S_WRITE_BACK,
      S_ALLOCATE
   } state_t;

   // Heap-ordered tree: node k (1-based) at bit k-1; a bit points at the side to replace.
   function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
      int node;
      node = 1;
      for (int l = 0; l < LEVELS; l++) begin
         node = 2 * node + (bits[node-1] ? 1 : 0);
      end
      return WAY_W'(node - WAYS);
   endfunction

   function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                    input logic [WAY_W-1:0]  way);
      logic [PLRU_W-1:0] nb;
      int node;
      nb   = bits;
      node = 1;
      for (int l = LEVELS - 1; l >= 0; l--) begin
         nb[node-1] = ~way[l];
         node       = 2 * node + (way[l] ? 1 : 0);
      end
      return nb;
   endfunction

   logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
   logic [LINE_W-1:0] r_line  [SETS][WAYS];
   logic [WAYS-1:0]   r_valid [SETS];
   logic [WAYS-1:0]   r_dirty [SETS];
   logic [PLRU_W-1:0] r_plru  [SETS];

   state_t            r_state;
   logic [WAY_W-1:0]  r_victim;
   logic              r_refill;
   logic              r_res_ready;
   logic [31:0]       r_res_data;
   logic              r_mem_valid;
   logic              r_mem_rw;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [LINE_W-1:0] r_mem_data;

   logic [INDEX_W-1:0] w_index;
   logic [TAG_W-1:0]   w_tag;
   logic [WORD_W-1:0]  w_word;
   logic               w_hit;
   logic [WAY_W-1:0]   w_hit_way;
   logic               w_inv_found;
   logic [WAY_W-1:0]   w_inv_way;
   logic [WAY_W-1:0]   w_victim;
   logic [31:0]        w_hit_word;
   logic               w_vict_dirty;
   logic               w_fill;
   logic               w_wr_hit;
   logic               w_unused;

   assign w_index  = bus.cpu_req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
   assign w_tag    = bus.cpu_req_addr[ADDR_W-1:OFFSET_W+INDEX_W];
   assign w_word   = bus.cpu_req_addr[OFFSET_W-1:2];
   assign w_unused = ^bus.cpu_req_addr[1:0];

   always_comb begin
      w_hit       = 1'b0;
      w_hit_way   = '0;
      w_inv_found = 1'b0;
      w_inv_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_valid[w_index][w] && (r_tag[w_index][w] == w_tag) && !w_hit) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
         if (!r_valid[w_index][w] && !w_inv_found) begin
            w_inv_found = 1'b1;
            w_inv_way   = WAY_W'(w);
         end
      end
      w_victim = w_inv_found ? w_inv_way : plru_victim(r_plru[w_index]);
   end

   assign w_hit_word   = r_line[w_index][w_hit_way][{w_word, 5'd0} +: 32];
   assign w_vict_dirty = r_valid[w_index][w_victim] && r_dirty[w_index][w_victim];
   assign w_fill       = !i_rst && (r_state == S_ALLOCATE) && bus.mem_data_ready;
   assign w_wr_hit     = !i_rst && (r_state == S_COMPARE) && w_hit && bus.cpu_req_rw;

   // Tag and line storage carry no reset; only valid/dirty/PLRU need clearing.
   always_ff @(posedge i_clk) begin
      if (w_fill) begin
         r_line[w_index][r_victim] <= bus.mem_data_data;
         r_tag[w_index][r_victim]  <= w_tag;
      end else if (w_wr_hit) begin
         r_line[w_index][w_hit_way][{w_word, 5'd0} +: 32] <= bus.cpu_req_data;
      end
   end

`ifdef SA_CACHE_STATS_EN
   logic [31:0] r_stat_hits;
   logic [31:0] r_stat_misses;
   logic [31:0] r_stat_writebacks;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_victim    <= '0;
         r_refill    <= 1'b0;
         r_res_ready <= 1'b0;
         r_res_data  <= '0;
         r_mem_valid <= 1'b0;
         r_mem_rw    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_data  <= '0;
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
            r_plru[s]  <= '0;
         end
`ifdef SA_CACHE_STATS_EN
         r_stat_hits       <= '0;
         r_stat_misses     <= '0;
         r_stat_writebacks <= '0;
`endif
      end else begin
         r_res_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.cpu_req_valid) begin
                  r_refill <= 1'b0;
                  r_state  <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               if (w_hit) begin
                  r_res_ready     <= 1'b1;
                  r_res_data      <= w_hit_word;
                  r_plru[w_index] <= plru_touch(r_plru[w_index], w_hit_way);
                  if (bus.cpu_req_rw) begin
                     r_dirty[w_index][w_hit_way] <= 1'b1;
                  end
`ifdef SA_CACHE_STATS_EN
                  if (!r_refill && (r_stat_hits != 32'hFFFF_FFFF)) begin
                     r_stat_hits <= r_stat_hits + 32'd1;
                  end
`endif
                  r_state <= S_IDLE;
               end else begin
                  r_victim <= w_victim;
`ifdef SA_CACHE_STATS_EN
                  if (r_stat_misses != 32'hFFFF_FFFF) begin
                     r_stat_misses <= r_stat_misses + 32'd1;
                  end
`endif
                  if (w_vict_dirty) begin
                     r_mem_rw   <= 1'b1;
                     r_mem_addr <= {r_tag[w_index][w_victim], w_index, {OFFSET_W{1'b0}}};
                     r_mem_data <= r_line[w_index][w_victim];
`ifdef SA_CACHE_STATS_EN
                     if (r_stat_writebacks != 32'hFFFF_FFFF) begin
                        r_stat_writebacks <= r_stat_writebacks + 32'd1;
                     end
`endif
                     r_state <= S_WRITE_BACK;
                  end else begin
                     r_mem_rw   <= 1'b0;
                     r_mem_addr <= {w_tag, w_index, {OFFSET_W{1'b0}}};
                     r_state    <= S_ALLOCATE;
                  end
               end
            end
            S_WRITE_BACK: begin
               // Valid drops for one cycle so the fill starts as a fresh request.
               if (bus.mem_data_ready) begin
                  r_mem_valid <= 1'b0;
                  r_mem_rw    <= 1'b0;
                  r_mem_addr  <= {w_tag, w_index, {OFFSET_W{1'b0}}};
                  r_state     <= S_ALLOCATE;
               end else begin
                  r_mem_valid <= 1'b1;
               end
            end
            S_ALLOCATE: begin
               if (bus.mem_data_ready) begin
                  r_mem_valid                <= 1'b0;
                  r_valid[w_index][r_victim] <= 1'b1;
                  r_dirty[w_index][r_victim] <= 1'b0;
                  r_refill                   <= 1'b1;
                  r_state                    <= S_COMPARE;
               end else begin
                  r_mem_valid <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.cpu_res_ready = r_res_ready;
   assign bus.cpu_res_data  = r_res_data;
   assign bus.mem_req_valid = r_mem_valid;
   assign bus.mem_req_rw    = r_mem_rw;
   assign bus.mem_req_addr  = r_mem_addr;
   assign bus.mem_req_data  = r_mem_data;

`ifdef SA_CACHE_STATS_EN
   assign o_stat_hits       = r_stat_hits;
   assign o_stat_misses     = r_stat_misses;
   assign o_stat_writebacks = r_stat_writebacks;
`endif
endmodule

// File: tb/tb_sa_cache.sv
// Directed bench for sa_cache (2 ways, 256 sets, 4-word lines).
// Counter checks are compiled in when SA_CACHE_STATS_EN is defined.
module tb_sa_cache;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   logic [31:0] rd;

   always #5 clk = ~clk;

   sa_cache_if #(.ADDR_W(32), .LINE_WORDS(4)) bus ();

`ifdef SA_CACHE_STATS_EN
   logic [31:0] st_hits, st_misses, st_wbs;
`endif

   sa_cache #(.WAYS(2), .SETS(256), .LINE_WORDS(4), .ADDR_W(32)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
`ifdef SA_CACHE_STATS_EN
      ,
      .o_stat_hits       (st_hits),
      .o_stat_misses     (st_misses),
      .o_stat_writebacks (st_wbs)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.cpu_req_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] wd);
      bus.cpu_req_valid = 1'b1;
      bus.cpu_req_rw    = rw;
      bus.cpu_req_addr  = addr;
      bus.cpu_req_data  = wd;
   endtask

   task automatic wait_memreq(input string tag);
      for (int i = 0; i < 40 && !bus.mem_req_valid; i++) tick();
      chk({tag, "_memreq"}, bus.mem_req_valid, 1'b1);
   endtask

   task automatic mem_reply(input logic [127:0] line);
      bus.mem_data_ready = 1'b1;
      bus.mem_data_data  = line;
      tick();
      bus.mem_data_ready = 1'b0;
   endtask

   task automatic finish_res(input string tag, output logic [31:0] d);
      for (int i = 0; i < 40 && !bus.cpu_res_ready; i++) tick();
      chk({tag, "_res"}, bus.cpu_res_ready, 1'b1);
      d = bus.cpu_res_data;
      bus.cpu_req_valid = 1'b0;
   endtask

   task automatic hit(input string tag, input logic rw, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp);
      issue(rw, addr, wd);
      tick();
      chk({tag, "_rdy0"}, bus.cpu_res_ready, 1'b0);
      tick();
      chk({tag, "_rdy1"}, bus.cpu_res_ready, 1'b1);
      if (!rw) chk({tag, "_data"}, bus.cpu_res_data, exp);
      chk({tag, "_nomem"}, bus.mem_req_valid, 1'b0);
      bus.cpu_req_valid = 1'b0;
   endtask

   task automatic miss(input string tag, input logic rw, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_maddr,
                       input logic [127:0] fill, input logic [31:0] exp);
      logic [31:0] d;
      issue(rw, addr, wd);
      wait_memreq(tag);
      chk({tag, "_mrw"}, bus.mem_req_rw, 1'b0);
      chk({tag, "_maddr"}, bus.mem_req_addr, exp_maddr);
      mem_reply(fill);
      finish_res(tag, d);
      if (!rw) chk({tag, "_data"}, d, exp);
   endtask

   initial begin
      rst                = 1'b1;
      bus.cpu_req_valid  = 1'b0;
      bus.cpu_req_rw     = 1'b0;
      bus.cpu_req_addr   = '0;
      bus.cpu_req_data   = '0;
      bus.mem_data_ready = 1'b0;
      bus.mem_data_data  = '0;
      do_reset();

      chk("rst_res_ready", bus.cpu_res_ready, 1'b0);
      chk("rst_res_data",  bus.cpu_res_data,  32'h0);
      chk("rst_mem_valid", bus.mem_req_valid, 1'b0);
      chk("rst_mem_rw",    bus.mem_req_rw,    1'b0);
      chk("rst_mem_addr",  bus.mem_req_addr,  32'h0);

      // Cold read with exact miss timing.
      issue(1'b0, 32'h0000_1234, 32'h0);
      tick();
      chk("cold_n0_valid", bus.mem_req_valid, 1'b0);
      tick();
      chk("cold_n1_valid", bus.mem_req_valid, 1'b0);
      tick();
      chk("cold_n2_valid", bus.mem_req_valid, 1'b1);
      chk("cold_rw",       bus.mem_req_rw,    1'b0);
      chk("cold_addr",     bus.mem_req_addr,  32'h0000_1230);
      mem_reply(128'h00000004_00000003_CAFEBABE_00000001);
      chk("cold_m0_ready", bus.cpu_res_ready, 1'b0);
      chk("cold_m0_valid", bus.mem_req_valid, 1'b0);
      tick();
      chk("cold_m1_ready", bus.cpu_res_ready, 1'b1);
      chk("cold_data",     bus.cpu_res_data,  32'hCAFEBABE);
      bus.cpu_req_valid = 1'b0;
      tick();
      chk("cold_pulse",    bus.cpu_res_ready, 1'b0);

      // Back-to-back hits in the same line.
      hit("rehit", 1'b0, 32'h0000_1234, 32'h0, 32'hCAFEBABE);
      hit("word2", 1'b0, 32'h0000_1238, 32'h0, 32'h0000_0003);

      // PLRU replacement in set 0x23.
      do_reset();
      miss("lru_a", 1'b0, 32'h0000_1230, 32'h0, 32'h0000_1230,
           128'h00000013_00000012_00000011_00000010, 32'h10);
      miss("lru_b", 1'b0, 32'h0000_2230, 32'h0, 32'h0000_2230,
           128'h00000023_00000022_00000021_00000020, 32'h20);
      hit("lru_a2", 1'b0, 32'h0000_1230, 32'h0, 32'h10);
      miss("lru_c", 1'b0, 32'h0000_3230, 32'h0, 32'h0000_3230,
           128'h00000033_00000032_00000031_00000030, 32'h30);
      hit("lru_a3", 1'b0, 32'h0000_1230, 32'h0, 32'h10);
      miss("lru_b2", 1'b0, 32'h0000_2230, 32'h0, 32'h0000_2230,
           128'h00000023_00000022_00000021_00000020, 32'h20);

      // Dirty eviction: 3 misses, 5 first-pass hits, 1 write-back.
      do_reset();
      miss("wr_a", 1'b1, 32'h0000_1230, 32'h1122_3344, 32'h0000_1230,
           128'h0000000D_0000000C_0000000B_0000000A, 32'h0);
      hit("wr_rd0", 1'b0, 32'h0000_1230, 32'h0, 32'h1122_3344);
      hit("wr_rd1", 1'b0, 32'h0000_1234, 32'h0, 32'h0000_000B);
      miss("wr_b", 1'b0, 32'h0000_2230, 32'h0, 32'h0000_2230,
           128'h000000B3_000000B2_000000B1_000000B0, 32'hB0);
      hit("wr_b0", 1'b0, 32'h0000_2230, 32'h0, 32'hB0);
      hit("wr_b1", 1'b0, 32'h0000_2234, 32'h0, 32'hB1);
      issue(1'b0, 32'h0000_3230, 32'h0);
      wait_memreq("wb");
      chk("wb_rw",   bus.mem_req_rw,   1'b1);
      chk("wb_addr", bus.mem_req_addr, 32'h0000_1230);
      chk("wb_data", bus.mem_req_data, 128'h0000000D_0000000C_0000000B_11223344);
      mem_reply(128'h0);
      chk("wb_gap", bus.mem_req_valid, 1'b0);
      tick();
      chk("fill_valid", bus.mem_req_valid, 1'b1);
      chk("fill_rw",    bus.mem_req_rw,    1'b0);
      chk("fill_addr",  bus.mem_req_addr,  32'h0000_3230);
      mem_reply(128'h000000C3_000000C2_000000C1_000000C0);
      finish_res("wb_c", rd);
      chk("wb_c_data", rd, 32'hC0);
      hit("wr_c0", 1'b0, 32'h0000_3230, 32'h0, 32'hC0);
`ifdef SA_CACHE_STATS_EN
      chk("stat_hits",   st_hits,   32'd5);
      chk("stat_misses", st_misses, 32'd3);
      chk("stat_wbs",    st_wbs,    32'd1);
      do_reset();
      chk("stat_hits_rst",   st_hits,   32'd0);
      chk("stat_misses_rst", st_misses, 32'd0);
      chk("stat_wbs_rst",    st_wbs,    32'd0);
`endif

      // Reset in the middle of a fill abandons it.
      do_reset();
      issue(1'b0, 32'h0000_4560, 32'h0);
      wait_memreq("abort");
      rst = 1'b1;
      tick();
      chk("abort_valid", bus.mem_req_valid, 1'b0);
      rst = 1'b0;
      bus.cpu_req_valid = 1'b0;
      mem_reply(128'h00000000_00000000_00000000_DEADBEEF);
      chk("stray_ready", bus.cpu_res_ready, 1'b0);
      tick();
      chk("stray_ready2", bus.cpu_res_ready, 1'b0);
      chk("stray_valid",  bus.mem_req_valid, 1'b0);
      miss("reread", 1'b0, 32'h0000_4560, 32'h0, 32'h0000_4560,
           128'h00000000_00000000_00000000_00000456, 32'h456);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
